// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 types, pad constant and block-count helper
package sha256_pkg;
  typedef logic [31:0] word_t;
  typedef logic [511:0] block_t;
  localparam word_t SHA256_PAD_WORD = 32'h8000_0000;
  function automatic int sha256_num_blocks(input int num_words);
    return (num_words + 18) / 16;
  endfunction
endpackage

// File: rtl/sha256_msg_padder_if.sv
// sha256_msg_padder_if: 512-bit block stream with valid/ready handshake
interface sha256_msg_padder_if;
  import sha256_pkg::*;
  logic blk_valid;
  logic blk_ready;
  block_t blk_data;
  logic [7:0] blk_idx;
  logic blk_last;
  modport master (output blk_valid, blk_data, blk_idx, blk_last, input blk_ready);
  modport slave (input blk_valid, blk_data, blk_idx, blk_last, output blk_ready);
endinterface

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: fetches a message and emits SHA-256 padded 512-bit blocks; SHA_PAD_BSWAP_EN byte-reverses memory words
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic [15:0] message_addr,
  output logic mem_clk,
  output logic mem_we,
  output logic [15:0] mem_addr,
  input  word_t mem_read_data,
  sha256_msg_padder_if.master blk,
  output logic busy,
  output logic done
);
  if (NUM_OF_WORDS < 1 || NUM_OF_WORDS > 4000) begin : g_range
    $fatal(1, "NUM_OF_WORDS out of range 1..4000");
  end
  localparam int NB = sha256_num_blocks(NUM_OF_WORDS);
  localparam logic [63:0] LEN = 64'(NUM_OF_WORDS) * 64'd32;
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, FINISH} state_t;
  state_t state, nxt;
  logic [4:0] t;
  logic [15:0] base;
  block_t buffer;
  logic last_blk, xfer;
  // Slot t-1 is captured in cycle t, so the global index lags the address counter by one
  function automatic word_t slot_word(input int w, input logic [3:0] s, input logic last, input word_t d);
    word_t m;
`ifdef SHA_PAD_BSWAP_EN
    m = {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    m = d;
`endif
    return w < NUM_OF_WORDS ? m : w == NUM_OF_WORDS ? SHA256_PAD_WORD :
           last && s == 4'd14 ? LEN[63:32] : last && s == 4'd15 ? LEN[31:0] : '0;
  endfunction
  assign mem_clk = clk;
  assign mem_we = 1'b0;
  assign last_blk = int'(blk.blk_idx) == NB - 1;
  assign xfer = blk.blk_valid && blk.blk_ready;
  assign blk.blk_last = blk.blk_valid && last_blk;
  // Next-state and status outputs
  always_comb begin
    nxt = state == IDLE ? (start ? FETCH : IDLE) :
          state == FETCH ? (t == 5'd16 ? PRESENT : FETCH) :
          state == PRESENT ? (xfer ? (last_blk ? FINISH : FETCH) : PRESENT) : IDLE;
    busy = state == FETCH || state == PRESENT;
    done = state == FINISH;
    mem_addr = state == FETCH ? base + 16'({blk.blk_idx, t[3:0]}) : '0;
  end
  // State register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  // Fetch counter, block assembly and output block register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      t <= '0;
      base <= '0;
      buffer <= '0;
      blk.blk_valid <= 1'b0;
      blk.blk_data <= '0;
      blk.blk_idx <= '0;
    end else begin
      if (state == IDLE && start) begin
        base <= message_addr;
        blk.blk_idx <= '0;
        t <= '0;
      end
      if (state == FETCH) begin
        t <= t + 5'd1;
        if (t != 5'd0)
          buffer <= {buffer[479:0], slot_word(int'({blk.blk_idx, 4'd0}) + int'(t) - 1, 4'(t - 5'd1), last_blk, mem_read_data)};
      end
      if (state == PRESENT) begin
        if (!blk.blk_valid) begin
          blk.blk_data <= buffer;
          blk.blk_valid <= 1'b1;
        end else if (blk.blk_ready) begin
          blk.blk_valid <= 1'b0;
          t <= '0;
          if (!last_blk) blk.blk_idx <= blk.blk_idx + 8'd1;
        end
      end
    end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: scoreboard bench for three message lengths (20, 13, 14 words)
module tb_sha256_msg_padder;
  typedef struct {logic [511:0] data; logic [7:0] idx; logic last;} exp_t;
  logic clk = 0, reset_n = 0;
  logic st20 = 0, st13 = 0, st14 = 0;
  logic [15:0] ad20 = 0, ad13 = 0, ad14 = 0;
  logic mc20, mc13, mc14, we20, we13, we14;
  logic [15:0] ma20, ma13, ma14;
  logic [31:0] rd20, rd13, rd14;
  logic busy20, busy13, busy14, done20, done13, done14;
  int total = 0, bad = 0;
  exp_t q20[$], q13[$], q14[$];
  sha256_msg_padder_if b20();
  sha256_msg_padder_if b13();
  sha256_msg_padder_if b14();
  sha256_msg_padder #(.NUM_OF_WORDS(20)) d20 (.clk(clk), .reset_n(reset_n), .start(st20), .message_addr(ad20),
    .mem_clk(mc20), .mem_we(we20), .mem_addr(ma20), .mem_read_data(rd20), .blk(b20), .busy(busy20), .done(done20));
  sha256_msg_padder #(.NUM_OF_WORDS(13)) d13 (.clk(clk), .reset_n(reset_n), .start(st13), .message_addr(ad13),
    .mem_clk(mc13), .mem_we(we13), .mem_addr(ma13), .mem_read_data(rd13), .blk(b13), .busy(busy13), .done(done13));
  sha256_msg_padder #(.NUM_OF_WORDS(14)) d14 (.clk(clk), .reset_n(reset_n), .start(st14), .message_addr(ad14),
    .mem_clk(mc14), .mem_we(we14), .mem_addr(ma14), .mem_read_data(rd14), .blk(b14), .busy(busy14), .done(done14));
  always #5 clk = ~clk;
  function automatic logic [31:0] memval(input logic [15:0] a);
    return 32'(a) - 32'h0000_00FF;
  endfunction
  function automatic logic [31:0] conv(input logic [31:0] d);
`ifdef SHA_PAD_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction
  function automatic logic [511:0] exp_block(input int n, input logic [15:0] base, input int b);
    logic [511:0] r = '0;
    int nb = (n + 18) / 16;
    for (int s = 0; s < 16; s++) begin
      int w = 16 * b + s;
      logic [31:0] v;
      v = w < n ? conv(memval(16'(int'(base) + w))) : w == n ? 32'h8000_0000 :
          (b == nb - 1 && s == 15) ? 32'(n * 32) : 32'h0;
      r[511 - 32 * s -: 32] = v;
    end
    return r;
  endfunction
  function automatic exp_t mk(input int n, input logic [15:0] base, input int b);
    exp_t e;
    e.data = exp_block(n, base, b);
    e.idx = 8'(b);
    e.last = b == (n + 18) / 16 - 1;
    return e;
  endfunction
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always_ff @(posedge clk) begin
    rd20 <= memval(ma20);
    rd13 <= memval(ma13);
    rd14 <= memval(ma14);
  end
  always @(negedge clk) if (b20.blk_valid && b20.blk_ready) begin : mon20
    exp_t e;
    chk("d20_pending", 512'(q20.size() > 0), 512'(1));
    if (q20.size() > 0) begin
      e = q20.pop_front();
      chk("d20_data", b20.blk_data, e.data);
      chk("d20_idx", 512'(b20.blk_idx), 512'(e.idx));
      chk("d20_last", 512'(b20.blk_last), 512'(e.last));
    end
  end
  always @(negedge clk) if (b13.blk_valid && b13.blk_ready) begin : mon13
    exp_t e;
    chk("d13_pending", 512'(q13.size() > 0), 512'(1));
    if (q13.size() > 0) begin
      e = q13.pop_front();
      chk("d13_data", b13.blk_data, e.data);
      chk("d13_idx", 512'(b13.blk_idx), 512'(e.idx));
      chk("d13_last", 512'(b13.blk_last), 512'(e.last));
    end
  end
  always @(negedge clk) if (b14.blk_valid && b14.blk_ready) begin : mon14
    exp_t e;
    chk("d14_pending", 512'(q14.size() > 0), 512'(1));
    if (q14.size() > 0) begin
      e = q14.pop_front();
      chk("d14_data", b14.blk_data, e.data);
      chk("d14_idx", 512'(b14.blk_idx), 512'(e.idx));
      chk("d14_last", 512'(b14.blk_last), 512'(e.last));
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic go20(input logic [15:0] a);
    ad20 = a;
    st20 = 1;
    @(posedge clk);
    #1 st20 = 0;
    ad20 = 16'hFFFF;
  endtask
  task automatic wait_valid20(output int c);
    c = 0;
    do begin
      @(posedge clk);
      c++;
      #1;
    end while (!b20.blk_valid && c < 40);
  endtask
  task automatic check_reset20(input string tag);
    chk({tag, "_valid"}, 512'(b20.blk_valid), 512'(0));
    chk({tag, "_data"}, b20.blk_data, 512'(0));
    chk({tag, "_idx"}, 512'(b20.blk_idx), 512'(0));
    chk({tag, "_last"}, 512'(b20.blk_last), 512'(0));
    chk({tag, "_busy"}, 512'(busy20), 512'(0));
    chk({tag, "_done"}, 512'(done20), 512'(0));
    chk({tag, "_maddr"}, 512'(ma20), 512'(0));
    chk({tag, "_we"}, 512'(we20), 512'(0));
  endtask
  initial begin
    int c;
    b20.blk_ready = 1;
    b13.blk_ready = 1;
    b14.blk_ready = 1;
    #12;
    check_reset20("rst");
    @(posedge clk);
    #1 reset_n = 1;
    q20.push_back(mk(20, 16'h0100, 0));
    q20.push_back(mk(20, 16'h0100, 1));
    go20(16'h0100);
    chk("t1_busy", 512'(busy20), 512'(1));
    wait_valid20(c);
    chk("t1_lat0", 512'(c), 512'(18));
    chk("t1_w0", 512'(b20.blk_data[511:480]), 512'(conv(32'd1)));
    @(posedge clk);
    #1 chk("t1_drop", 512'(b20.blk_valid), 512'(0));
    chk("t1_idx1", 512'(b20.blk_idx), 512'(1));
    wait_valid20(c);
    chk("t1_lat1", 512'(c), 512'(18));
    chk("t1_len", 512'(b20.blk_data[31:0]), 512'(32'h0000_0280));
    chk("t1_pad", 512'(b20.blk_data[383:352]), 512'(32'h8000_0000));
    @(posedge clk);
    #1 chk("t1_done", 512'(done20), 512'(1));
    chk("t1_busy_lo", 512'(busy20), 512'(0));
    @(posedge clk);
    #1 chk("t1_done_pulse", 512'(done20), 512'(0));
    chk("t1_retain", b20.blk_data, exp_block(20, 16'h0100, 1));
    b20.blk_ready = 0;
    q20.push_back(mk(20, 16'h0180, 0));
    q20.push_back(mk(20, 16'h0180, 1));
    go20(16'h0180);
    wait_valid20(c);
    chk("t2_lat0", 512'(c), 512'(18));
    for (int i = 0; i < 5; i++) begin
      st20 = i == 1;
      ad20 = 16'h0700;
      @(posedge clk);
      #1 chk("t2_hold_valid", 512'(b20.blk_valid), 512'(1));
      chk("t2_hold_data", b20.blk_data, exp_block(20, 16'h0180, 0));
      chk("t2_hold_idx", 512'(b20.blk_idx), 512'(0));
    end
    st20 = 0;
    b20.blk_ready = 1;
    @(posedge clk);
    #1 chk("t2_xfer", 512'(b20.blk_valid), 512'(0));
    wait_valid20(c);
    chk("t2_lat1", 512'(c), 512'(18));
    @(posedge clk);
    #1 chk("t2_done", 512'(done20), 512'(1));
    @(posedge clk);
    #1 go20(16'h0100);
    repeat (7) @(posedge clk);
    #1 chk("t3_maddr7", 512'(ma20), 512'(16'h0107));
    reset_n = 0;
    #1 check_reset20("t3_abort");
    @(posedge clk);
    #1 reset_n = 1;
    q20.push_back(mk(20, 16'h0300, 0));
    q20.push_back(mk(20, 16'h0300, 1));
    go20(16'h0300);
    wait_valid20(c);
    chk("t3_lat0", 512'(c), 512'(18));
    c = 0;
    while (!done20 && c < 60) begin
      @(posedge clk);
      #1 c++;
    end
    chk("t3_done", 512'(done20), 512'(1));
    q13.push_back(mk(13, 16'h0040, 0));
    ad13 = 16'h0040;
    st13 = 1;
    @(posedge clk);
    #1 st13 = 0;
    c = 0;
    while (!done13 && c < 60) begin
      @(posedge clk);
      #1 c++;
    end
    chk("d13_done", 512'(done13), 512'(1));
    chk("d13_len", 512'(b13.blk_data[31:0]), 512'(32'h0000_01A0));
    q14.push_back(mk(14, 16'h0500, 0));
    q14.push_back(mk(14, 16'h0500, 1));
    ad14 = 16'h0500;
    st14 = 1;
    @(posedge clk);
    #1 st14 = 0;
    c = 0;
    while (!done14 && c < 100) begin
      @(posedge clk);
      #1 c++;
    end
    chk("d14_done", 512'(done14), 512'(1));
    chk("d14_len", 512'(b14.blk_data[31:0]), 512'(32'h0000_01C0));
    chk("q20_empty", 512'(q20.size()), 512'(0));
    chk("q13_empty", 512'(q13.size()), 512'(0));
    chk("q14_empty", 512'(q14.size()), 512'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Upstream feeder for the SHA-256 compression engine.
- Reads an unpadded message of NUM_OF_WORDS 32-bit words from word-addressed memory starting at message_addr.
- Applies SHA-256 padding: one 1-bit, zero fill, then a 64-bit big-endian bit length.
- Delivers the result as a sequence of 512-bit blocks over a valid/ready handshake, one block at a time.

Parameters:
- NUM_OF_WORDS, 20, message length in 32-bit words. Legal range 1..4000; out-of-range values are an elaboration-time fatal error.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin a message; sampled only in IDLE
- message_addr  in  16  word address of message word 0; captured when start is accepted
- mem_clk  out  1  equals clk
- mem_we  out  1  constant 0 (read-only client)
- mem_addr  out  16  read address
- mem_read_data  in  32  read data; valid the cycle after its address is driven
- blk_valid  out  1  blk_data holds a complete block
- blk_ready  in  1  consumer accepts the block
- blk_data  out  512  block; word 0 in [511:480], word 15 in [31:0]
- blk_idx  out  8  index of the presented block, 0-based
- blk_last  out  1  presented block is the final one
- busy  out  1  high from start acceptance until the last block is accepted
- done  out  1  one-cycle pulse after the last block is accepted

Behaviour:
- Reset values: blk_valid=0, blk_data=0, blk_idx=0, blk_last=0, busy=0, done=0, mem_addr=0, mem_we=0.
- States:
  - IDLE
  - FETCH: 17 cycles per block
  - PRESENT: holds blk_valid
  - FINISH: done pulse
- Block count: NB = (NUM_OF_WORDS+18)/16 (integer division). Examples: N=13 gives 1, N=14 gives 2, N=20 gives 2.
- Global word index: w = 16*blk_idx + t, for t = 0..15.
- Word value at index w:
  - w < N: memory word at message_addr + w.
  - w == N: 32'h8000_0000.
  - Word 14 of the last block: upper 32 bits of L = N*32 (0 for all legal N).
  - Word 15 of the last block: lower 32 bits of L.
  - Otherwise: 0.
  - The word-14/15 rule applies only to the last block; length words are never placed earlier.
- FETCH sequencing:
  - In cycle t (0..15) drive mem_addr = message_addr + w.
  - mem_addr is driven every cycle, even for pad slots; the data for pad slots is discarded.
  - In cycle t+1, capture slot t from mem_read_data or from the pad rule.
  - Cycle 16 is the drain cycle: it captures slot 15, then the block moves to PRESENT.
- Latency:
  - blk_valid rises exactly 18 cycles after the edge that accepts start.
  - For each later block, blk_valid rises 18 cycles after the edge where blk_valid & blk_ready is high.
- Handshake:
  - A transfer occurs on a clock edge with blk_valid & blk_ready both high.
  - While blk_valid is high and blk_ready is low, blk_data, blk_idx and blk_last stay stable.
  - blk_valid never drops without a transfer.
  - blk_ready is ignored while blk_valid is low.
- After a transfer:
  - Not the last block: blk_valid=0, blk_idx increments, next FETCH starts.
  - Last block: go to FINISH. done=1 for one cycle, busy=0, then IDLE.
- blk_last = (blk_idx == NB-1) whenever blk_valid is high.
- start while busy is ignored; message_addr changes while busy are ignored.
- Asynchronous reset at any time, including mid-FETCH or while presenting, aborts to IDLE with the reset values above. The partially built block is discarded.
- blk_data retains the last block after completion; it is cleared only by reset.

Optional Feature:
- Macro: SHA_PAD_BSWAP_EN.
- Defined: each memory word is byte-reversed before capture (bytes 0..3 become 3..0), for little-endian message storage. Pad and length words are never swapped.
- Undefined: memory words are used unmodified.
- Timing is identical in both builds.

Decomposition:
- Package sha256_pkg:
  - word_t (logic [31:0]) and block_t (logic [511:0])
  - SHA256_PAD_WORD = 32'h8000_0000
  - function sha256_num_blocks(num_words), also available for the compression engine
- No sub-module. The pad-rule word select is a local function; FSM and buffer stay in one module.

Test Plan:
- N=20, memory[0..19]=i+1, message_addr=16'h0100, blk_ready=1:
  - 2 blocks. Block 0 words = 1..16.
  - Block 1: words 0-3 = 17..20, word 4 = 0x80000000, words 5-14 = 0, word 15 = 0x00000280, blk_last=1.
  - done one cycle after the second transfer.
- N=13: 1 block. Word 13 = 0x80000000, word 14 = 0, word 15 = 0x000001A0, blk_last=1 on block 0.
- N=14:
  - Block 0: word 14 = 0x80000000, word 15 = 0, blk_last=0.
  - Block 1: words 0-14 = 0, word 15 = 0x000001C0.
- Backpressure: hold blk_ready=0 for 5 cycles after blk_valid rises. blk_valid, blk_data and blk_idx stay stable. The transfer occurs on the first ready edge, and the next blk_valid rises 18 cycles later.
- Reset and start handling:
  - Assert reset_n=0 at FETCH cycle 7 of block 0: all outputs return to reset values.
  - A new start afterwards produces the correct block 0 after 18 cycles.
  - A start pulse while busy has no effect.
- With SHA_PAD_BSWAP_EN, memory word 0x11223344 appears as 0x44332211. Pad word 0x80000000 and length word 0x00000280 are unchanged.
